// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants, FSM states and status bit positions for the framebuffer arbiter
package gpu_pkg;

  // Bus window and register map within it
  localparam logic [7:0]  GPU_ADDRESS    = 8'b00000010;
  localparam logic [55:0] CONTROL_OFFSET = 56'd0;
  localparam logic [55:0] STATUS_OFFSET  = 56'd2;
  localparam logic [55:0] CHARS_OFFSET   = 56'd4;

  // Status register layout
  localparam int STATUS_EN_BIT       = 0;
  localparam int STATUS_STARVED_BIT  = 1;
  localparam int STATUS_SCAN_BIT     = 2;
  localparam int STATUS_CONFLICT_LSB = 16;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_RD,
    CPU_RD,
    CPU_WR,
    REG
  } state_t;

  typedef enum logic [1:0] {
    REGION_CTRL,
    REGION_STATUS,
    REGION_CHARS,
    REGION_OTHER
  } region_t;

endpackage

// File: rtl/gpu_addr_decode.sv
// rtl/gpu_addr_decode.sv - combinational decode of a cpu bus address into window hit, region and framebuffer index
module gpu_addr_decode
  import gpu_pkg::*;
#(
  parameter int FB_ADDR_W = 12,
  parameter int FB_DEPTH  = 4096
) (
  input  logic                 cpu_req,
  input  logic [63:0]          cpu_addr,
  output logic                 hit,
  output region_t              region,
  output logic                 in_range,
  output logic [FB_ADDR_W-1:0] idx
);

  logic [55:0] off;
  logic [55:0] idx_full;

  assign off      = cpu_addr[55:0];
  assign idx_full = off - CHARS_OFFSET;

  // Classify the offset; in_range is only meaningful for the chars region
  always_comb begin
    hit      = cpu_req && (cpu_addr[63:56] == GPU_ADDRESS);
    region   = REGION_OTHER;
    if (off == CONTROL_OFFSET) begin
      region = REGION_CTRL;
    end else if (off == STATUS_OFFSET) begin
      region = REGION_STATUS;
    end else if (off >= CHARS_OFFSET) begin
      region = REGION_CHARS;
    end
    in_range = (off >= CHARS_OFFSET) && (idx_full < 56'(FB_DEPTH));
    idx      = idx_full[FB_ADDR_W-1:0];
  end

endmodule

// File: rtl/gpu_fb_arbiter.sv
// rtl/gpu_fb_arbiter.sv - framebuffer RAM arbiter between cpu bus and scanout, plus GPU control/status registers (option GPU_CONFLICT_COUNT_EN)
module gpu_fb_arbiter
  import gpu_pkg::*;
#(
  parameter int FB_ADDR_W    = 12,
  parameter int FB_DEPTH     = 4096,
  parameter int MAX_SCAN_RUN = 4
) (
  input  logic                 clock50,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic [63:0]          cpu_addr,
  input  logic [63:0]          cpu_wdata,
  output logic [63:0]          cpu_rdata,
  output logic                 cpu_ack,
  input  logic                 scan_req,
  input  logic [FB_ADDR_W-1:0] scan_addr,
  output logic [63:0]          scan_data,
  output logic                 scan_valid,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [63:0]          fb_wdata,
  output logic                 fb_we,
  input  logic [63:0]          fb_rdata,
  output logic                 ctrl_enable,
  output logic                 busy
);

  localparam int               RUN_W   = $clog2(MAX_SCAN_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_SCAN_RUN);

  state_t               state;
  state_t               state_nx;
  logic                 hit;
  region_t              region;
  logic                 in_range;
  logic [FB_ADDR_W-1:0] idx;

  logic [RUN_W-1:0]     run_cnt;
  logic                 control;
  logic                 ack_q;
  logic                 valid_q;
  logic                 ram_rd_q;
  logic [63:0]          rdata_q;
  logic [FB_ADDR_W-1:0] addr_q;
  logic [63:0]          wdata_q;
  logic                 starved;
  logic                 respond;
  logic                 scan_grant;
  logic                 cpu_grant;
  logic [63:0]          status_word;
  logic [63:0]          reg_rdata;

`ifdef GPU_CONFLICT_COUNT_EN
  logic [15:0]          conflict_cnt;
`endif

  gpu_addr_decode #(
    .FB_ADDR_W (FB_ADDR_W),
    .FB_DEPTH  (FB_DEPTH)
  ) u_decode (
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .hit      (hit),
    .region   (region),
    .in_range (in_range),
    .idx      (idx)
  );

  assign starved = hit && (run_cnt == RUN_MAX);
  // The IDLE cycle that carries an ack/valid never grants, so a requester
  // still holding its level request that cycle is not served twice.
  assign respond = ack_q | valid_q;

  // FSM state register
  always_ff @(posedge clock50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Grant decision, next state and RAM strobes
  always_comb begin
    state_nx   = state;
    scan_grant = 1'b0;
    cpu_grant  = 1'b0;
    fb_we      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (!respond) begin
          if (scan_req && !starved) begin
            scan_grant = 1'b1;
            state_nx   = SCAN_RD;
          end else if (hit) begin
            cpu_grant = 1'b1;
            // Out-of-range chars accesses are answered like a register
            // access so the RAM port is left untouched.
            if (region == REGION_CHARS && in_range) begin
              state_nx = cpu_write ? CPU_WR : CPU_RD;
            end else begin
              state_nx = REG;
            end
          end
        end
      end
      CPU_WR: begin
        fb_we    = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status and register read mux
  always_comb begin
    status_word                     = '0;
    status_word[STATUS_EN_BIT]      = control;
    status_word[STATUS_STARVED_BIT] = (run_cnt == RUN_MAX);
    status_word[STATUS_SCAN_BIT]    = scan_req;
`ifdef GPU_CONFLICT_COUNT_EN
    status_word[STATUS_CONFLICT_LSB +: 16] = conflict_cnt;
`endif
    case (region)
      REGION_CTRL:   reg_rdata = {63'b0, control};
      REGION_STATUS: reg_rdata = status_word;
      default:       reg_rdata = '0;
    endcase
  end

  // Response flags, RAM address/data registers, control bit and starvation counter
  always_ff @(posedge clock50) begin
    if (reset) begin
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      ram_rd_q <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      control  <= 1'b0;
      run_cnt  <= '0;
    end else begin
      ack_q    <= (state == CPU_RD) || (state == CPU_WR) || (state == REG);
      valid_q  <= (state == SCAN_RD);
      ram_rd_q <= (state == CPU_RD);
      rdata_q  <= '0;
      if (state == REG && !cpu_write) begin
        rdata_q <= reg_rdata;
      end
      if (state == REG && cpu_write && region == REGION_CTRL) begin
        control <= cpu_wdata[0];
      end
      if (scan_grant) begin
        addr_q <= scan_addr;
      end else if (cpu_grant && state_nx != REG) begin
        addr_q <= idx;
      end
      if (cpu_grant && state_nx == CPU_WR) begin
        wdata_q <= cpu_wdata;
      end
      if (!hit || cpu_grant) begin
        run_cnt <= '0;
      end else if (scan_grant && run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

`ifdef GPU_CONFLICT_COUNT_EN
  // Saturating count of IDLE cycles where both requesters contend
  always_ff @(posedge clock50) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (state == REG && cpu_write && region == REGION_STATUS) begin
      conflict_cnt <= '0;
    end else if (state == IDLE && hit && scan_req && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

  assign cpu_ack     = ack_q;
  assign cpu_rdata   = ack_q ? (ram_rd_q ? fb_rdata : rdata_q) : 64'd0;
  assign scan_valid  = valid_q;
  assign scan_data   = valid_q ? fb_rdata : 64'd0;
  assign fb_addr     = addr_q;
  assign fb_wdata    = wdata_q;
  assign ctrl_enable = control;

endmodule

// File: tb/tb_gpu_fb_arbiter.sv
// tb/tb_gpu_fb_arbiter.sv - directed self-checking bench for gpu_fb_arbiter
module tb_gpu_fb_arbiter;

  logic        clock50;
  logic        reset;
  logic        cpu_req;
  logic        cpu_write;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_ack;
  logic        scan_req;
  logic [11:0] scan_addr;
  logic [63:0] scan_data;
  logic        scan_valid;
  logic [11:0] fb_addr;
  logic [63:0] fb_wdata;
  logic        fb_we;
  logic [63:0] fb_rdata;
  logic        ctrl_enable;
  logic        busy;

  logic [63:0] mem [0:4095];
  int          checks;
  int          errors;
  int          we_cnt;
  int          ack_cnt;
  logic [11:0] we_addr;
  logic [63:0] we_data;

  localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

  gpu_fb_arbiter dut (
    .clock50     (clock50),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .scan_data   (scan_data),
    .scan_valid  (scan_valid),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .fb_we       (fb_we),
    .fb_rdata    (fb_rdata),
    .ctrl_enable (ctrl_enable),
    .busy        (busy)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  // Synchronous RAM with one-cycle read latency, read-before-write
  always @(posedge clock50) begin
    fb_rdata <= mem[fb_addr];
    if (fb_we) mem[fb_addr] = fb_wdata;
  end

  // Count RAM writes and cpu acks between edges
  always @(negedge clock50) begin
    if (!reset) begin
      if (fb_we) begin
        we_cnt  = we_cnt + 1;
        we_addr = fb_addr;
        we_data = fb_wdata;
      end
      if (cpu_ack) ack_cnt = ack_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                            output logic [63:0] rd, output int lat);
    cpu_req   = 1'b1;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    rd        = '0;
    lat       = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock50); #1;
      if (cpu_ack) begin
        rd  = cpu_rdata;
        lat = i;
        break;
      end
    end
    cpu_req   = 1'b0;
    cpu_write = 1'b0;
    @(posedge clock50); #1;
  endtask

  initial begin
    logic [63:0] rd;
    int          lat;
    int          nvalid;
    int          nack0;
    int          nwe0;
    logic [63:0] sdata;

    checks = 0; errors = 0; we_cnt = 0; ack_cnt = 0;
    we_addr = '0; we_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = PAT | 64'(i);
    reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    scan_req = 1'b0; scan_addr = '0;
    repeat (3) @(posedge clock50);
    #1;
    check("reset_flags", {59'b0, cpu_ack, scan_valid, fb_we, ctrl_enable, busy}, 64'd0);
    check("reset_cpu_rdata", cpu_rdata, 64'd0);
    check("reset_fb_addr", {52'b0, fb_addr}, 64'd0);
    check("reset_fb_wdata", fb_wdata, 64'd0);
    reset = 1'b0;
    @(posedge clock50); #1;

    // framebuffer write then read back
    cpu_access(1'b1, {8'h02, 56'd4}, 64'hDEAD, rd, lat);
    check("wr_lat", 64'(lat), 64'd2);
    check("wr_we_cnt", 64'(we_cnt), 64'd1);
    check("wr_we_addr", {52'b0, we_addr}, 64'd0);
    check("wr_we_data", we_data, 64'hDEAD);
    cpu_access(1'b0, {8'h02, 56'd4}, 64'd0, rd, lat);
    check("rd_lat", 64'(lat), 64'd2);
    check("rd_data", rd, 64'hDEAD);
    cpu_access(1'b0, {8'h02, 56'd11}, 64'd0, rd, lat);
    check("rd_idx7", rd, 64'hA5A5_0000_0000_0007);
    check("rd_idx7_fb_addr", {52'b0, fb_addr}, 64'd7);

    // control and status registers
    cpu_access(1'b1, {8'h02, 56'd0}, 64'h3, rd, lat);
    check("ctrl_enable", {63'b0, ctrl_enable}, 64'd1);
    cpu_access(1'b0, {8'h02, 56'd0}, 64'd0, rd, lat);
    check("ctrl_read", rd, 64'd1);
    cpu_access(1'b0, {8'h02, 56'd2}, 64'd0, rd, lat);
    check("status_lo", {48'b0, rd[15:0]}, 64'd1);
    check("status_hi", {32'b0, rd[63:32]}, 64'd0);
    cpu_access(1'b1, {8'h02, 56'd2}, 64'd0, rd, lat);
    check("status_wr_ignored", {63'b0, ctrl_enable}, 64'd1);
    cpu_access(1'b0, {8'h02, 56'd1}, 64'd0, rd, lat);
    check("other_off_read", rd, 64'd0);
    check("other_off_ack", 64'(lat), 64'd2);

    // out-of-range framebuffer index
    nwe0 = we_cnt;
    cpu_access(1'b0, {8'h02, 56'd4100}, 64'd0, rd, lat);
    check("oor_rd_lat", 64'(lat), 64'd2);
    check("oor_rd_data", rd, 64'd0);
    check("oor_fb_addr", {52'b0, fb_addr}, 64'd7);
    cpu_access(1'b1, {8'h02, 56'd4100}, 64'h55, rd, lat);
    check("oor_wr_no_we", 64'(we_cnt - nwe0), 64'd0);
    check("oor_wr_lat", 64'(lat), 64'd2);

    // single scan fetch
    scan_req = 1'b1; scan_addr = 12'd9;
    lat = -1; sdata = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock50); #1;
      if (scan_valid) begin lat = i; sdata = scan_data; break; end
    end
    scan_req = 1'b0;
    check("scan_lat", 64'(lat), 64'd2);
    check("scan_data", sdata, 64'hA5A5_0000_0000_0009);
    @(posedge clock50); #1;

    // starvation: scan held continuously against a pending cpu read
    scan_req = 1'b1; scan_addr = 12'd3;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = {8'h02, 56'd4};
    nvalid = 0; lat = -1; rd = '0; sdata = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock50); #1;
      if (scan_valid) begin
        if (nvalid == 0) sdata = scan_data;
        nvalid++;
      end
      if (cpu_ack) begin lat = i; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
    check("starve_scans", 64'(nvalid), 64'd4);
    check("starve_ack_lat", 64'(lat), 64'd14);
    check("starve_rdata", rd, 64'hDEAD);
    check("starve_scan_data", sdata, 64'hA5A5_0000_0000_0003);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock50); #1;
      if (scan_valid) begin lat = i; break; end
    end
    scan_req = 1'b0;
    check("scan_resume", 64'(lat), 64'd3);
    repeat (2) @(posedge clock50);
    #1;

    // cpu request outside the GPU window
    nack0 = ack_cnt; nwe0 = we_cnt; nvalid = 0;
    scan_req = 1'b1; scan_addr = 12'd1;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = {8'h03, 56'd4}; cpu_wdata = 64'hBAD;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock50); #1;
      if (scan_valid) nvalid++;
    end
    cpu_req = 1'b0; cpu_write = 1'b0; scan_req = 1'b0;
    check("nohit_no_ack", 64'(ack_cnt - nack0), 64'd0);
    check("nohit_no_we", 64'(we_cnt - nwe0), 64'd0);
    check("nohit_scans", 64'(nvalid), 64'd7);
    repeat (3) @(posedge clock50);
    #1;

    // reset during CPU_RD
    nack0 = ack_cnt;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = {8'h02, 56'd4};
    @(posedge clock50); #1;
    check("cpu_rd_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clock50); #1;
    check("rst_mid_flags", {59'b0, cpu_ack, scan_valid, fb_we, ctrl_enable, busy}, 64'd0);
    check("rst_mid_rdata", cpu_rdata, 64'd0);
    check("rst_mid_fb_addr", {52'b0, fb_addr}, 64'd0);
    reset = 1'b0; cpu_req = 1'b0;
    repeat (3) @(posedge clock50);
    #1;
    check("rst_mid_no_ack", 64'(ack_cnt - nack0), 64'd0);
    cpu_access(1'b0, {8'h02, 56'd4}, 64'd0, rd, lat);
    check("post_rst_rd", rd, 64'hDEAD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpu_fb_arbiter.md
Name: gpu_fb_arbiter

Overview:
Sequences all accesses to the GPU character framebuffer RAM (synchronous, 1-cycle read latency) on the clock50 domain. Shares the single RAM port between two requesters: the processor bus (memory-mapped reads/writes) and the VGA scanout fetcher (read-only, real-time). Also implements the GPU control and status registers at the GPU's bus window. Sits between the bus interface and the framebuffer RAM, replacing direct bus-to-RAM wiring.

Parameters:
GPU_ADDRESS, 8'b00000010, bus window select matched against cpu_addr[63:56]
CONTROL_OFFSET, 56'd0, control register offset
STATUS_OFFSET, 56'd2, status register offset
CHARS_OFFSET, 56'd4, first framebuffer word offset
FB_ADDR_W, 12, framebuffer index width
FB_DEPTH, 4096, valid framebuffer words; must be at most 2**FB_ADDR_W
MAX_SCAN_RUN, 4, consecutive scan grants allowed while a cpu request waits

Ports:
clock50  in  1  sole clock
reset  in  1  synchronous, active-high
cpu_req  in  1  level; held until cpu_ack
cpu_write  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  64  bus address; stable while cpu_req
cpu_wdata  in  64  write data
cpu_rdata  out  64  read data; valid when cpu_ack
cpu_ack  out  1  one-cycle completion pulse
scan_req  in  1  level; held until scan_valid
scan_addr  in  FB_ADDR_W  framebuffer index to fetch
scan_data  out  64  fetched word; valid when scan_valid
scan_valid  out  1  one-cycle pulse
fb_addr  out  FB_ADDR_W  RAM address
fb_wdata  out  64  RAM write data
fb_we  out  1  RAM write enable
fb_rdata  in  64  RAM read data; 1 cycle after fb_addr
ctrl_enable  out  1  control reg bit 0; scanout enable
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; control=0; run counter=0. A reset mid-access aborts it, emits no ack or valid, and leaves the RAM unwritten beyond any fb_we already issued.
- Decode: hit = cpu_req & (cpu_addr[63:56]==GPU_ADDRESS); off = cpu_addr[55:0]. A non-hit cpu_req is ignored: no ack, and it never blocks scan.
- FSM states: IDLE, SCAN_RD, CPU_RD, CPU_WR, REG.
- Grant rule in IDLE:
  - scan_req wins unless a cpu hit is pending and run counter==MAX_SCAN_RUN; then the cpu wins.
  - Run counter: increments on each scan grant while a cpu hit is pending; clears on a cpu grant or when no cpu hit is pending.
- SCAN_RD: grant cycle drives fb_addr=scan_addr. Next cycle: scan_valid=1, scan_data=fb_rdata, return to IDLE. Latency is 2 cycles from IDLE grant to scan_valid.
- CPU framebuffer access (off>=CHARS_OFFSET): idx=off-CHARS_OFFSET.
  - If idx>=FB_DEPTH: no RAM access; reads return 0; ack after 1 cycle.
  - Read (CPU_RD): fb_addr=idx[FB_ADDR_W-1:0]; ack with cpu_rdata=fb_rdata 1 cycle later.
  - Write (CPU_WR): fb_we=1 for exactly one cycle with fb_addr=idx and fb_wdata=cpu_wdata; ack on the next cycle.
- REG state (off<CHARS_OFFSET):
  - off==CONTROL_OFFSET: write latches bit 0 into control; read returns {63'b0,control}.
  - off==STATUS_OFFSET: read-only; writes ignored; read returns {61'b0, scan_req, run counter==MAX_SCAN_RUN, ctrl_enable}.
  - Other offsets: read 0, write ignored.
  - Ack 1 cycle after grant.
- ctrl_enable=0 does not block scan_req; the arbiter serves regardless. Gating is the fetcher's responsibility.
- Each ack or valid is followed by at least one IDLE cycle, so back-to-back requests from one requester are spaced 3 cycles for reads.
- Simultaneous cpu and scan requests in IDLE: scan wins except under starvation, as above.
- fb_addr holds its last value when idle; fb_we=0 outside CPU_WR.

Optional Feature:
GPU_CONFLICT_COUNT_EN:
- Defined: a 16-bit saturating counter of cycles in IDLE where both a cpu hit and scan_req are asserted. Readable at status bits [31:16]. Cleared by reset or by any write to STATUS_OFFSET.
- Undefined: status bits [31:16] read 0 and the counter is absent.

Decomposition:
- Package gpu_pkg: GPU_ADDRESS, the CONTROL, STATUS and CHARS offsets, the FSM state enum, and status bit positions.
- One sub-module, gpu_addr_decode: combinational hit, region (ctrl/status/chars/other), in-range flag and idx.

Test Plan:
- CPU write 0xDEAD to address {8'h02,56'd4}, then read it back -> one fb_we at fb_addr=0, ack; read ack returns 0xDEAD.
- scan_req continuously with cpu_req read pending, MAX_SCAN_RUN=4 -> exactly 4 scan_valid pulses precede cpu_ack; then scan resumes.
- cpu_addr top byte 8'h03 -> no cpu_ack, fb_we never asserted, scan unaffected.
- Write 1 to control, read control and status -> ctrl_enable=1; reads return 1 and bit0=1.
- Read idx=FB_DEPTH -> cpu_ack with cpu_rdata=0 and no RAM address change.
- Assert reset during the CPU_RD cycle -> no ack; all outputs 0 next cycle; the FSM is in IDLE.
